// File: rtl/arrow_plotter.sv
// Arrow glyph plotter: walks shaft then two 45-degree head strokes, one pixel
// per TICKS_PER_PIXEL clocks, driving a VGA-adapter style x/y/colour/plot port.
module arrow_plotter #(
  parameter int X_W             = 8,
  parameter int Y_W             = 7,
  parameter int COLOUR_W        = 3,
  parameter int H_RES           = 160,
  parameter int V_RES           = 120,
  parameter int SHAFT_LEN       = 8,
  parameter int HEAD_LEN        = 4,
  parameter int TICKS_PER_PIXEL = 3125000,
  parameter int BG_COLOUR       = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          dir,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                erase,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);
  localparam int SEG_MAX = (SHAFT_LEN > HEAD_LEN) ? SHAFT_LEN : HEAD_LEN;
  localparam int CW      = $clog2(SEG_MAX + 1);
  localparam int TW      = (TICKS_PER_PIXEL > 1) ? $clog2(TICKS_PER_PIXEL) : 1;
  localparam logic [TW-1:0]       TICK_LAST = TW'(TICKS_PER_PIXEL - 1);
  localparam logic [CW-1:0]       S_LAST    = CW'(SHAFT_LEN - 1);
  localparam logic [CW-1:0]       H_LAST    = CW'((HEAD_LEN > 0) ? HEAD_LEN - 1 : 0);
  localparam logic [X_W:0]        X_LIM     = (X_W+1)'(H_RES);
  localparam logic [Y_W:0]        Y_LIM     = (Y_W+1)'(V_RES);
  localparam logic [COLOUR_W-1:0] BG        = COLOUR_W'(BG_COLOUR);
  localparam logic [1:0] D_UP = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_RIGHT = 2'b11;

  typedef enum logic [2:0] {IDLE, SHAFT, HEAD_A, HEAD_B, DONE} state_t;

  state_t              state, state_n;
  logic [TW-1:0]       tick, tick_n;
  logic [CW-1:0]       cnt, cnt_n, off;
  logic [1:0]          dir_q, dir_n;
  logic [X_W-1:0]      x0_q, x0_n;
  logic [Y_W-1:0]      y0_q, y0_n;
  logic [COLOUR_W-1:0] col_q, col_n;
  logic                erase_q, erase_n, acc, seg_last, slot_n;
  logic [X_W:0]        xb, ox, xc;
  logic [Y_W:0]        yb, oy, yc;

  assign acc      = (state == IDLE) && start;
  assign seg_last = (state == SHAFT) ? (cnt == S_LAST) : (cnt == H_LAST);
  assign busy     = (state == SHAFT) || (state == HEAD_A) || (state == HEAD_B);
  assign done     = (state == DONE);

  always_comb begin
    state_n = state;
    tick_n  = tick;
    cnt_n   = cnt;
    case (state)
      IDLE: if (start) begin
        state_n = SHAFT;
        tick_n  = '0;
        cnt_n   = '0;
      end
      SHAFT, HEAD_A, HEAD_B: begin
        if (abort) begin
          state_n = IDLE;
          tick_n  = '0;
          cnt_n   = '0;
        end else if (tick == TICK_LAST) begin
          tick_n = '0;
          if (seg_last) begin
            cnt_n = '0;
            case (state)
              SHAFT:   state_n = (HEAD_LEN == 0) ? DONE : HEAD_A;
              HEAD_A:  state_n = HEAD_B;
              default: state_n = DONE;
            endcase
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-cycle pacing state, so a pixel is
  // visible in the same cycle its slot comes due.
  assign dir_n   = acc ? dir       : dir_q;
  assign x0_n    = acc ? x0        : x0_q;
  assign y0_n    = acc ? y0        : y0_q;
  assign col_n   = acc ? colour_in : col_q;
  assign erase_n = acc ? erase     : erase_q;
  assign slot_n  = ((state_n == SHAFT) || (state_n == HEAD_A) || (state_n == HEAD_B))
                   && (tick_n == TICK_LAST);

  always_comb begin
    off = (state_n == SHAFT) ? cnt_n : cnt_n + 1'b1;
    xb  = {1'b0, x0_n};
    yb  = {1'b0, y0_n};
    ox  = (X_W+1)'(off);
    oy  = (Y_W+1)'(off);
    xc  = xb;
    yc  = yb;
    case (state_n)
      SHAFT: case (dir_n)
        D_UP:    yc = yb + oy;
        D_DOWN:  yc = yb - oy;
        D_LEFT:  xc = xb + ox;
        default: xc = xb - ox;
      endcase
      HEAD_A: begin
        xc = (dir_n == D_RIGHT) ? xb - ox : xb + ox;
        yc = (dir_n == D_DOWN)  ? yb - oy : yb + oy;
      end
      HEAD_B: begin
        xc = (dir_n == D_LEFT) ? xb + ox : xb - ox;
        yc = (dir_n == D_UP)   ? yb + oy : yb - oy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tick    <= '0;
      cnt     <= '0;
      dir_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      col_q   <= '0;
      erase_q <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
    end else begin
      state   <= state_n;
      tick    <= tick_n;
      cnt     <= cnt_n;
      dir_q   <= dir_n;
      x0_q    <= x0_n;
      y0_q    <= y0_n;
      col_q   <= col_n;
      erase_q <= erase_n;
      plot    <= slot_n && (xc < X_LIM) && (yc < Y_LIM);
      if (slot_n) begin
        x      <= xc[X_W-1:0];
        y      <= yc[Y_W-1:0];
        colour <= erase_n ? BG : col_n;
      end
    end
  end
endmodule

// File: tb/tb_arrow_plotter.sv
// Scoreboard bench for arrow_plotter: three instances with different pacing
// and head lengths; expected pixels/done pulses are queued with their cycle.
module tb_arrow_plotter;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic [2:0] start = '0, abort = '0;
  logic [1:0] dir = '0;
  logic [7:0] x0 = '0;
  logic [6:0] y0 = '0;
  logic [2:0] colour_in = '0;
  logic       erase = 1'b0;
  logic [7:0] xo [3];
  logic [6:0] yo [3];
  logic [2:0] co [3];
  logic       plot_o [3], busy_o [3], done_o [3];

  typedef struct {int d; int k; int x; int y; int c; int t;} ev_t;
  ev_t q[$];
  int  cyc = 0, compared = 0, mismatched = 0;
  int  plot_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arrow_plotter #(.TICKS_PER_PIXEL(1), .HEAD_LEN(4)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort[0]), .dir(dir),
    .x0(x0), .y0(y0), .colour_in(colour_in), .erase(erase),
    .x(xo[0]), .y(yo[0]), .colour(co[0]), .plot(plot_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  arrow_plotter #(.TICKS_PER_PIXEL(4), .HEAD_LEN(4)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort[1]), .dir(dir),
    .x0(x0), .y0(y0), .colour_in(colour_in), .erase(erase),
    .x(xo[1]), .y(yo[1]), .colour(co[1]), .plot(plot_o[1]), .busy(busy_o[1]), .done(done_o[1]));
  arrow_plotter #(.TICKS_PER_PIXEL(2), .HEAD_LEN(0), .BG_COLOUR(1)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .abort(abort[2]), .dir(dir),
    .x0(x0), .y0(y0), .colour_in(colour_in), .erase(erase),
    .x(xo[2]), .y(yo[2]), .colour(co[2]), .plot(plot_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  task automatic check_ev(input int d, input int k);
    ev_t e;
    bit  ok;
    compared++;
    if (q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_%s dut%0d cyc=%0d got x=%0d y=%0d c=%0d, none expected",
               (k != 0) ? "done" : "plot", d, cyc, xo[d], yo[d], co[d]);
      return;
    end
    e  = q.pop_front();
    ok = (e.d == d) && (e.k == k) && (e.t == cyc);
    if (k == 0) ok = ok && (e.x == int'(xo[d])) && (e.y == int'(yo[d])) && (e.c == int'(co[d]));
    else        ok = ok && !busy_o[d];
    if (!ok) begin
      mismatched++;
      $display("FAIL event dut%0d kind=%0d got cyc=%0d x=%0d y=%0d c=%0d busy=%0b; expected dut%0d kind=%0d cyc=%0d x=%0d y=%0d c=%0d",
               d, k, cyc, xo[d], yo[d], co[d], busy_o[d], e.d, e.k, e.t, e.x, e.y, e.c);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      for (int d = 0; d < 3; d++) begin
        if (plot_o[d]) begin
          plot_cnt[d] = plot_cnt[d] + 1;
          check_ev(d, 0);
        end
        if (done_o[d]) check_ev(d, 1);
      end
    end
  end

  // Issue a draw to dut d and queue its expected pixels (only the first lim
  // when lim >= 0, in which case no done pulse is expected).
  task automatic launch(input int d, input logic [1:0] dr, input int px, input int py,
                        input logic [2:0] c, input logic er, input bit hold, input int lim,
                        output int e_acc);
    int h, t, p, ec, seg, off, sx, sy, xc, yc;
    h  = (d == 2) ? 0 : 4;
    t  = (d == 0) ? 1 : (d == 1) ? 4 : 2;
    p  = 8 + 2 * h;
    ec = er ? ((d == 2) ? 1 : 0) : int'(c);
    dir = dr; x0 = px[7:0]; y0 = py[6:0]; colour_in = c; erase = er;
    start[d] = 1'b1;
    e_acc = cyc + 1;
    for (int k = 0; k < p; k++) begin
      seg = (k < 8) ? 0 : (k < 8 + h) ? 1 : 2;
      off = (seg == 0) ? k : (seg == 1) ? k - 7 : k - 7 - h;
      case (seg)
        0: begin sx = (dr == 2) ? 1 : (dr == 3) ? -1 : 0; sy = (dr == 0) ? 1 : (dr == 1) ? -1 : 0; end
        1: begin sx = (dr == 3) ? -1 : 1; sy = (dr == 1) ? -1 : 1; end
        default: begin sx = (dr == 2) ? 1 : -1; sy = (dr == 0) ? 1 : -1; end
      endcase
      xc = px + sx * off;
      yc = py + sy * off;
      if (lim >= 0 ? (k < lim) : (xc >= 0 && xc < 160 && yc >= 0 && yc < 120))
        q.push_back('{d, 0, xc, yc, ec, e_acc + (k + 1) * t - 1});
    end
    if (lim < 0) q.push_back('{d, 1, 0, 0, 0, e_acc + p * t});
    @(negedge clk);
    if (!hold) start[d] = 1'b0;
    dir = ~dr; x0 = 8'hA5; y0 = 7'h5A; colour_in = ~c; erase = ~er;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL timeout %0d events still pending after %0d cycles, expected 0", q.size(), budget);
      q.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic check_count(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s plot count got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int e, pc;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      compared++;
      if (xo[d] != 0 || yo[d] != 0 || co[d] != 0 || plot_o[d] || busy_o[d] || done_o[d]) begin
        mismatched++;
        $display("FAIL reset dut%0d got x=%0d y=%0d c=%0d plot=%0b busy=%0b done=%0b expected all 0",
                 d, xo[d], yo[d], co[d], plot_o[d], busy_o[d], done_o[d]);
      end
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    pc = plot_cnt[0];
    launch(0, 2'b00, 79, 63, 3'd5, 1'b0, 1'b0, -1, e);
    drain(100);
    check_count("up_t1", plot_cnt[0] - pc, 16);

    // start held through the draw and the done cycle; re-accept one cycle later
    launch(0, 2'b11, 100, 30, 3'd6, 1'b0, 1'b1, -1, e);
    while (cyc < e + 17) @(negedge clk);
    launch(0, 2'b01, 20, 100, 3'd1, 1'b0, 1'b0, -1, e);
    drain(100);

    launch(0, 2'b10, 40, 40, 3'd6, 1'b0, 1'b0, 6, e);
    while (cyc < e + 5) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    compared++;
    if (busy_o[0] || plot_o[0]) begin
      mismatched++;
      $display("FAIL abort busy=%0b plot=%0b expected 0 0", busy_o[0], plot_o[0]);
    end
    drain(50);

    abort[0] = 1'b1;
    launch(0, 2'b01, 50, 50, 3'd2, 1'b0, 1'b0, -1, e);
    abort[0] = 1'b0;
    drain(100);

    launch(1, 2'b11, 10, 20, 3'b100, 1'b0, 1'b0, 2, e);
    while (cyc < e + 9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    compared++;
    if (busy_o[1] || plot_o[1] || done_o[1]) begin
      mismatched++;
      $display("FAIL mid_reset busy=%0b plot=%0b done=%0b expected 0 0 0", busy_o[1], plot_o[1], done_o[1]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drain(50);

    launch(1, 2'b11, 10, 20, 3'b100, 1'b0, 1'b0, -1, e);
    drain(200);

    pc = plot_cnt[1];
    launch(1, 2'b10, 155, 60, 3'd3, 1'b0, 1'b0, -1, e);
    drain(200);
    check_count("left_clip", plot_cnt[1] - pc, 13);

    pc = plot_cnt[2];
    launch(2, 2'b01, 0, 5, 3'd7, 1'b1, 1'b0, -1, e);
    drain(100);
    check_count("erase_down_clip", plot_cnt[2] - pc, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
